// File: rtl/bytecode_fetch_ctrl.sv
// Bytecode fetch controller: requests bytes from next_byte_gen one at a time and assembles
// opcode plus big-endian operand. Define FETCH_TIMEOUT_EN for the wait timeout / fetch_error.
module bytecode_fetch_ctrl #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BOOT_PC       = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic                     nbg_start,
  output logic                     nbg_pc_reset,
  output logic [ADDRESS_WIDTH-1:0] nbg_pc_reset_value,
  input  logic                     nbg_ready,
  input  logic [7:0]               nbg_next_byte,
  input  logic                     branch_valid,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  output logic                     insn_valid,
  input  logic                     insn_ready,
  output logic [7:0]               opcode,
  output logic [15:0]              operand,
  output logic [1:0]               operand_len,
  output logic [ADDRESS_WIDTH-1:0] insn_pc
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                     fetch_error
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_INC = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, RELOAD, FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, PRESENT
`ifdef FETCH_TIMEOUT_EN
    , ERROR
`endif
  } state_t;

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    if (op == 8'h10 || op == 8'h12 || (op >= 8'h15 && op <= 8'h19) ||
        (op >= 8'h36 && op <= 8'h3A))
      return 2'd1;
    else if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA8))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [1:0]               args_left;
  logic [1:0]               dec_len;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0]               tmo_cnt;
`endif

  assign dec_len = decode_len(nbg_next_byte);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      nbg_start          <= 1'b0;
      nbg_pc_reset       <= 1'b1;
      nbg_pc_reset_value <= '0;
      insn_valid         <= 1'b0;
      opcode             <= 8'h00;
      operand            <= 16'h0000;
      operand_len        <= 2'd0;
      insn_pc            <= '0;
      pc                 <= BOOT_PC;
      args_left          <= 2'd0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt            <= 4'd0;
      fetch_error        <= 1'b0;
`endif
    end else begin
      nbg_start    <= 1'b0;
      nbg_pc_reset <= 1'b1;
      // A redirect beats everything else, including a byte arriving this cycle.
      if (branch_valid && state != IDLE) begin
        state              <= RELOAD;
        nbg_pc_reset       <= 1'b0;
        nbg_pc_reset_value <= branch_target;
        insn_valid         <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
        fetch_error        <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (run) begin
            state              <= RELOAD;
            nbg_pc_reset       <= 1'b0;
            nbg_pc_reset_value <= pc;
          end
          RELOAD: begin
            pc <= nbg_pc_reset_value;
            if (run) begin
              state     <= FETCH_OP;
              nbg_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          FETCH_OP: begin
            state <= WAIT_OP;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt <= 4'd0;
`endif
          end
          FETCH_ARG: begin
            state <= WAIT_ARG;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt <= 4'd0;
`endif
          end
          WAIT_OP: if (nbg_ready) begin
            opcode      <= nbg_next_byte;
            operand     <= 16'h0000;
            operand_len <= dec_len;
            args_left   <= dec_len;
            insn_pc     <= pc;
            pc          <= pc + PC_INC;
            if (dec_len == 2'd0) begin
              state      <= PRESENT;
              insn_valid <= 1'b1;
            end else begin
              state     <= FETCH_ARG;
              nbg_start <= 1'b1;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          // Flag shows in the 16th cycle spent without a byte.
          else if (tmo_cnt == 4'd14) begin
            state       <= ERROR;
            fetch_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
`endif
          WAIT_ARG: if (nbg_ready) begin
            operand   <= {operand[7:0], nbg_next_byte};
            args_left <= args_left - 2'd1;
            pc        <= pc + PC_INC;
            if (args_left == 2'd1) begin
              state      <= PRESENT;
              insn_valid <= 1'b1;
            end else begin
              state     <= FETCH_ARG;
              nbg_start <= 1'b1;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_cnt == 4'd14) begin
            state       <= ERROR;
            fetch_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
`endif
          PRESENT: if (insn_ready) begin
            insn_valid <= 1'b0;
            if (run) begin
              state     <= FETCH_OP;
              nbg_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          ERROR: insn_valid <= 1'b0;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bytecode_fetch_ctrl.md
BYTECODE_FETCH_CTRL -- requirements
Module: bytecode_fetch_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8, is the bytecode address width shared with next_byte_gen.
REQ-002 Parameter BOOT_PC, default 0, is the address reloaded when run first rises.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  level; high permits fetching.
REQ-006 nbg_start  out  1  one-cycle request for the next bytecode byte.
REQ-007 nbg_pc_reset  out  1  active-low PC load strobe to next_byte_gen.
REQ-008 nbg_pc_reset_value  out  ADDRESS_WIDTH  PC load value.
REQ-009 nbg_ready  in  1  nbg_next_byte valid this cycle.
REQ-010 nbg_next_byte  in  8  fetched byte.
REQ-011 branch_valid  in  1  one-cycle redirect request.
REQ-012 branch_target  in  ADDRESS_WIDTH  redirect address.
REQ-013 insn_valid  out  1  assembled instruction available.
REQ-014 insn_ready  in  1  consumer accepts instruction.
REQ-015 opcode  out  8  instruction opcode.
REQ-016 operand  out  16  operand bytes, big-endian, zero-extended.
REQ-017 operand_len  out  2  operand byte count, 0..2.
REQ-018 insn_pc  out  ADDRESS_WIDTH  address of the opcode byte.
REQ-019 fetch_error  out  1  sticky timeout flag; present only with FETCH_TIMEOUT_EN.

Function
REQ-020 States SHALL be IDLE, RELOAD, FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, PRESENT, and ERROR (ERROR only with the macro).
REQ-021 IDLE -> RELOAD with value BOOT_PC when run=1; while run=0, the block SHALL remain in IDLE.
REQ-022 RELOAD SHALL hold nbg_pc_reset=0 for exactly one cycle, load the shadow PC with the reload value, ignore nbg_ready, and go to FETCH_OP.
REQ-023 FETCH_OP and FETCH_ARG SHALL each assert nbg_start for exactly one cycle, then go to WAIT_OP or WAIT_ARG respectively.
REQ-024 In a WAIT state, a byte is captured on the cycle nbg_ready=1, and the shadow PC increments by 1, wrapping modulo 2^ADDRESS_WIDTH.
REQ-025 Operand-length decode SHALL be:
  - 1 for opcodes 0x10, 0x12, 0x15-0x19, 0x36-0x3A;
  - 2 for opcodes 0x11, 0x84, 0x99-0xA8;
  - 0 for all other opcodes.
REQ-026 WAIT_OP capture SHALL go to PRESENT if the decoded length is 0, and otherwise to FETCH_ARG.
REQ-027 WAIT_ARG capture SHALL go to FETCH_ARG if operand bytes remain, and otherwise to PRESENT.
REQ-028 Operand assembly: for length 1, operand = {8'h00, b1}; for length 2, operand = {b1, b2}.
REQ-029 In PRESENT, insn_valid=1 and all insn_* outputs SHALL stay stable until insn_valid&insn_ready; on acceptance the next state is FETCH_OP, with no idle cycle.
REQ-030 Minimum latency SHALL be: nbg_ready in WAIT_OP (0-operand opcode) -> insn_valid on the next cycle.
REQ-031 branch_valid=1 in any non-IDLE state SHALL:
  - abort the current fetch;
  - drop insn_valid on the next cycle;
  - go to RELOAD with branch_target.
REQ-032 If branch_valid and insn_valid&insn_ready occur in the same cycle, the instruction counts as accepted and the branch is taken.
REQ-033 branch_valid and nbg_ready in the same WAIT cycle: the branch wins and the byte is discarded.
REQ-034 run=0 SHALL take effect only at an instruction boundary (PRESENT accepted or FETCH_OP entry), returning to IDLE; a later run=1 reloads from the shadow PC, not from BOOT_PC.

Reset
REQ-035 Asserting reset SHALL asynchronously force:
  - state to IDLE;
  - nbg_start=0, nbg_pc_reset=1, nbg_pc_reset_value=0;
  - insn_valid=0, opcode=0, operand=0, operand_len=0, insn_pc=0;
  - shadow PC=BOOT_PC;
  - fetch_error=0.
REQ-036 Reset asserted mid-fetch SHALL abandon the instruction; the first fetch after release SHALL be preceded by RELOAD.

Configuration
REQ-037 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter runs in WAIT_OP and WAIT_ARG; 16 cycles without nbg_ready -> ERROR.
REQ-038 ERROR SHALL set fetch_error=1 and hold insn_valid=0; only branch_valid (-> RELOAD, fetch_error cleared) or reset exits ERROR.
REQ-039 Macro undefined: no counter, no ERROR state, no fetch_error port, and WAIT states wait indefinitely.

Verification
REQ-040 run=1, BOOT_PC=0x00, byte stream 0x04 -> opcode=0x04, operand_len=0, insn_pc=0x00; next fetch begins with insn_pc=0x01.
REQ-041 Stream 0x11,0x12,0x34 -> opcode=0x11, operand=0x1234, operand_len=2, exactly three nbg_start pulses.
REQ-042 insn_ready held 0 for 5 cycles in PRESENT -> outputs stable, no nbg_start issued; insn_ready=1 -> nbg_start on the next cycle.
REQ-043 branch_valid with target 0x40 during WAIT_ARG -> nbg_pc_reset=0 for one cycle with value 0x40; next insn_pc=0x40; the partial instruction is never presented.
REQ-044 Shadow PC at 0xFF, stream 0x10,0x7F -> insn_pc=0xFF, operand=0x007F, following insn_pc=0x01.
REQ-045 With FETCH_TIMEOUT_EN defined, nbg_ready held low after start -> fetch_error=1 at the 16th wait cycle; branch_valid clears it and reloads.
